// File: rtl/inst_encoder.sv
// Purpose: packs RISC-V instruction field bundles into 32-bit words and writes them to instruction memory.
// Latency: the word is on mem_wdata with mem_we high one cycle after the accept edge; it is held until mem_ack.
// Backpressure: in_ready is low while busy, full or done, and a write waits on mem_ack for as long as needed.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        done,
    output logic        full
);

    localparam int unsigned    CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q;
    logic           rdy_q;
    logic           we_q;
    logic           err_q;
    logic           done_q;
    logic           full_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  cnt_q;

    // Captured bundle fields
    logic [2:0]     fmt_q;
    logic [6:0]     opcode_q;
    logic [2:0]     funct3_q;
    logic [6:0]     funct7_q;
    logic [4:0]     rd_q;
    logic [4:0]     rs1_q;
    logic [4:0]     rs2_q;
    logic [31:0]    imm_q;
    logic           last_q;

    // Encoder results for the bundle held in the field registers
    logic [31:0]    word_d;
    logic           legal_d;
    logic [CW-1:0]  cnt_d;
    logic           is_shift;
    logic           fits12;
    logic           fits13;
    logic           fits21;

    assign in_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign done      = done_q;
    assign full      = full_q;

    // Immediate fits in N signed bits when all bits from N-1 upward agree
    assign fits12   = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign fits13   = (&imm_q[31:12]) | ~(|imm_q[31:12]);
    assign fits21   = (&imm_q[31:20]) | ~(|imm_q[31:20]);
    assign is_shift = (opcode_q == 7'b0010011) && ((funct3_q == 3'b001) || (funct3_q == 3'b101));

    // Count after a completed write, saturating at DEPTH
    assign cnt_d = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;

    // Form the instruction word and decide whether the immediate is representable
    always_comb begin
        word_d  = 32'h0;
        legal_d = 1'b1;
        case (fmt_q)
            3'd0: word_d = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            3'd1: begin
                if (is_shift) begin
                    word_d  = {funct7_q, imm_q[4:0], rs1_q, funct3_q, rd_q, opcode_q};
                    legal_d = ~(|imm_q[31:5]);
                end else begin
                    word_d  = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
                    legal_d = fits12;
                end
            end
            3'd2: begin
                word_d  = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
                legal_d = fits12;
            end
            3'd3: begin
                word_d  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                           imm_q[4:1], imm_q[11], opcode_q};
                legal_d = fits13 & ~imm_q[0];
            end
            3'd4: begin
                word_d  = {imm_q[31:12], rd_q, opcode_q};
                legal_d = ~(|imm_q[11:0]);
            end
            3'd5: begin
                word_d  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
                legal_d = fits21 & ~imm_q[0];
            end
            default: legal_d = 1'b0;
        endcase
    end

    // Register the bundle fields on accept so the encoder works from stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q    <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            last_q   <= 1'b0;
        end else if (in_valid && rdy_q) begin
            fmt_q    <= fmt;
            opcode_q <= opcode;
            funct3_q <= funct3;
            funct7_q <= funct7;
            rd_q     <= rd;
            rs1_q    <= rs1;
            rs2_q    <= rs2;
            imm_q    <= imm;
            last_q   <= last;
        end
    end

    // Control FSM with registered handshake, write-port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
        end else if (clear) begin
            // Restart wins over everything, including an outstanding write
            state_q <= S_IDLE;
            rdy_q   <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && rdy_q) begin
                        state_q <= S_ENC;
                        rdy_q   <= 1'b0;
                    end else begin
                        rdy_q   <= ~full_q;
                    end
                end
                S_ENC: begin
                    if (legal_d) begin
                        wdata_q <= word_d;
                        we_q    <= 1'b1;
                        state_q <= S_WR;
                    end else begin
                        // Rejected bundle: no write, address and count untouched, last ignored
                        err_q   <= 1'b1;
                        rdy_q   <= ~full_q;
                        state_q <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        we_q   <= 1'b0;
                        cnt_q  <= cnt_d;
                        full_q <= (cnt_d == DEPTH_C);
                        if (addr_q < 32'hFFFF_FFFC) begin
                            addr_q <= addr_q + 32'd4;
                        end
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rdy_q   <= (cnt_d != DEPTH_C);
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    rdy_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Purpose: randomized self-checking bench for inst_encoder against a transaction-level reference model.
// Latency: expectations are updated just after each rising edge; outputs are compared on every falling edge.
// Backpressure: mem_ack delays, clear and reset are injected mid-write; in_valid is toggled while in_ready is low.
module tb_inst_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        last = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        err;
    logic        done;
    logic        full;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .err(err), .done(done), .full(full)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit          chk_en      = 1'b0;
    bit          ready_known = 1'b0;
    bit          wdata_rst   = 1'b0;
    logic        exp_we, exp_err, exp_done, exp_full, exp_ready;
    logic [31:0] exp_addr, exp_wdata;
    int          m_n;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding from the instruction-format bit layouts, built arithmetically
    function automatic logic [31:0] enc(int f, int op, int f3, int f7, int rdv, int r1, int r2, logic [31:0] im);
        int v;
        v = int'(im);
        case (f)
            0: return 32'((f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op);
            1: if (op == 19 && (f3 == 1 || f3 == 5))
                   return 32'((f7 << 25) | ((v & 31) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op);
               else
                   return 32'(((v & 'hfff) << 20) | (r1 << 15) | (f3 << 12) | (rdv << 7) | op);
            2: return 32'((((v >> 5) & 'h7f) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | ((v & 31) << 7) | op);
            3: return 32'((((v >> 12) & 1) << 31) | (((v >> 5) & 'h3f) << 25) | (r2 << 20) | (r1 << 15) |
                          (f3 << 12) | (((v >> 1) & 'hf) << 8) | (((v >> 11) & 1) << 7) | op);
            4: return 32'((v & 32'hFFFF_F000) | (rdv << 7) | op);
            5: return 32'((((v >> 20) & 1) << 31) | (((v >> 1) & 'h3ff) << 21) | (((v >> 11) & 1) << 20) |
                          (((v >> 12) & 'hff) << 12) | (rdv << 7) | op);
            default: return 32'h0;
        endcase
    endfunction

    // Legality from signed numeric ranges
    function automatic bit legal(int f, int op, int f3, logic [31:0] im);
        int v;
        v = int'(im);
        case (f)
            0: return 1'b1;
            1: if (op == 19 && (f3 == 1 || f3 == 5)) return (v >= 0 && v <= 31);
               else return (v >= -2048 && v <= 2047);
            2: return (v >= -2048 && v <= 2047);
            3: return (v >= -4096 && v <= 4094 && (v & 1) == 0);
            4: return ((v & 'hfff) == 0);
            5: return (v >= -(1 << 20) && v <= (1 << 20) - 2 && (v & 1) == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", mem_addr, exp_addr);
            chk("err", 32'(err), 32'(exp_err));
            chk("done", 32'(done), 32'(exp_done));
            chk("full", 32'(full), 32'(exp_full));
            if (ready_known) chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if (exp_we || wdata_rst) chk("mem_wdata", mem_wdata, exp_wdata);
        end
    end

    task automatic model_clear();
        exp_addr = BASE; m_n = 0;
        exp_we = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_full = 1'b0;
        exp_ready = 1'b1; ready_known = 1'b1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; mem_ack = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_addr = BASE; m_n = 0; exp_wdata = 32'h0; wdata_rst = 1'b1;
        exp_we = 1'b0; exp_err = 1'b0; exp_done = 1'b0; exp_full = 1'b0;
        ready_known = 1'b0; chk_en = 1'b1;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_flags", {29'h0, err, done, full}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ready = 1'b1; ready_known = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1; mem_ack = 1'($urandom);
        @(posedge clk); #1;
        clear = 1'b0; mem_ack = 1'b0;
        model_clear();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            in_valid = exp_ready ? 1'b0 : 1'($urandom);
            mem_ack  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; mem_ack = 1'b0;
    endtask

    // One bundle; abort: 0 none, 1 clear mid-write, 2 reset mid-write
    task automatic send(int f, int op, int f3, int f7, int rdv, int r1, int r2,
                        logic [31:0] im, bit lst, int dly, int abort);
        logic [31:0] word;
        bit ok;
        word = enc(f, op, f3, f7, rdv, r1, r2, im);
        ok   = legal(f, op, f3, im);
        fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
        rd = 5'(rdv); rs1 = 5'(r1); rs2 = 5'(r2); imm = im; last = lst;
        in_valid = 1'b1; mem_ack = 1'($urandom);
        @(posedge clk); #1;
        // Scramble the bus so the encoder must use its captured copy
        in_valid = 1'b0;
        {fmt, opcode, funct3, funct7, rd, rs1, rs2} = 35'({$urandom, $urandom});
        imm = $urandom; last = 1'($urandom);
        exp_ready = 1'b0; wdata_rst = 1'b0;
        mem_ack = 1'($urandom);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (!ok) begin
            exp_err = 1'b1; exp_ready = ~exp_full;
            @(posedge clk); #1;
            exp_err = 1'b0;
            return;
        end
        exp_we = 1'b1; exp_wdata = word;
        for (int i = 0; i < dly; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (abort == 1) begin
            do_clear();
            return;
        end
        if (abort == 2) begin
            #2;
            do_reset();
            return;
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        exp_we = 1'b0;
        m_n = m_n + 1;
        if (exp_addr < 32'hFFFF_FFFC) exp_addr = exp_addr + 32'd4;
        exp_full = (m_n == DEPTH);
        if (lst) exp_done = 1'b1;
        else     exp_ready = ~exp_full;
    endtask

    int bounds[15] = '{2047, 2048, -2048, -2049, 31, 32, 4094, 4095, -4096, -4098,
                       (1 << 20) - 2, (1 << 20), -(1 << 20), -(1 << 20) - 2, 4096};

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return 32'($urandom_range(0, 63));
            2: return $urandom & 32'hFFFF_F000;
            3: return 32'($urandom_range(0, 1 << 22)) - 32'(1 << 21);
            4: return $urandom;
            default: return 32'(bounds[$urandom_range(0, 14)]);
        endcase
    endfunction

    initial begin
        // Pin the reference model with hand-computed encodings and limits
        chk("model_addi", enc(1, 19, 0, 0, 1, 0, 0, 32'd5), 32'h0050_0093);
        chk("model_sub", enc(0, 51, 0, 32, 3, 1, 2, 32'd0), 32'h4020_81B3);
        chk("model_beq_m8", enc(3, 99, 0, 0, 0, 1, 2, -32'sd8), 32'hFE20_8CE3);
        chk("model_b_odd", 32'(legal(3, 99, 0, 32'd5)), 32'h0);
        chk("model_i_max", 32'(legal(1, 3, 0, 32'd2047)), 32'h1);
        chk("model_i_over", 32'(legal(1, 3, 0, 32'd2048)), 32'h0);
        chk("model_j_max", 32'(legal(5, 111, 0, 32'((1 << 20) - 2))), 32'h1);
        chk("model_j_over", 32'(legal(5, 111, 0, 32'(1 << 20))), 32'h0);

        #3;
        do_reset();
        chk("first_ready", 32'(in_ready), 32'h1);

        // addi with ack held off for three cycles
        send(1, 19, 0, 0, 1, 0, 0, 32'd5, 1'b0, 3, 0);
        chk("addi_next_addr", mem_addr, BASE + 32'd4);
        // sub fills the two-word memory
        send(0, 51, 0, 32, 3, 1, 2, 32'd0, 1'b0, 0, 0);
        chk("full_flag", 32'(full), 32'h1);
        chk("full_ready", 32'(in_ready), 32'h0);
        idle(3);
        do_clear();
        chk("clear_addr", mem_addr, BASE);
        chk("clear_ready", 32'(in_ready), 32'h1);
        // misaligned branch rejected, then beq -8 as last instruction
        send(3, 99, 0, 0, 0, 1, 2, 32'd5, 1'b0, 0, 0);
        chk("berr_addr", mem_addr, BASE);
        send(3, 99, 0, 0, 0, 1, 2, -32'sd8, 1'b1, 1, 0);
        chk("done_flag", 32'(done), 32'h1);
        chk("done_ready", 32'(in_ready), 32'h0);
        idle(2);
        do_clear();
        // clear and reset while a write is outstanding
        send(4, 55, 0, 0, 5, 0, 0, 32'h1234_5000, 1'b0, 2, 1);
        send(5, 111, 0, 0, 1, 0, 0, 32'd2048, 1'b0, 1, 2);
        idle(2);

        for (int it = 0; it < 300; it++) begin
            int f, op, a;
            if (exp_done || exp_full) begin
                idle($urandom_range(0, 3));
                do_clear();
            end
            f  = $urandom_range(0, 7);
            op = ($urandom_range(0, 3) == 0) ? 19 : $urandom_range(0, 127);
            a  = $urandom_range(0, 19);
            send(f, op, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(),
                 1'($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                 (a == 0) ? 1 : ((a == 1) ? 2 : 0));
            idle($urandom_range(0, 2));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first instruction-memory word written.
REQ-002 Parameter DEPTH, default 1024, maximum words written before full.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clear  in  1  synchronous restart: address=BASE_ADDR, count=0, state IDLE, flags low.
REQ-006 in_valid  in  1  field bundle valid.
REQ-007 in_ready  out  1  encoder can accept a bundle.
REQ-008 fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-009 opcode  in  7; funct3  in  3; funct7  in  7; rd, rs1, rs2  in  5 each; imm  in  32 (signed value, not pre-shifted).
REQ-010 last  in  1  bundle is final instruction of program.
REQ-011 mem_we  out  1; mem_addr  out  32 (byte address); mem_wdata  out  32; mem_ack  in  1 (write accepted).
REQ-012 err  out  1  one-cycle pulse, bundle rejected; done  out  1  program complete; full  out  1  DEPTH words written.

Function
REQ-013 FSM states IDLE, ENC, WR, DONE; in_ready=1 only in IDLE with full=0.
REQ-014 Accept on rising edge with in_valid&&in_ready; all inputs (incl. last) registered; IDLE->ENC.
REQ-015 ENC: form word from registered fields, register into mem_wdata, ENC->WR; mem_we rises on first edge after the accept edge.
REQ-016 R: {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-017 I: {imm[11:0],rs1,funct3,rd,opcode}; if opcode=7'b0010011 and funct3 in {001,101}: {funct7,imm[4:0],rs1,funct3,rd,opcode}.
REQ-018 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-019 B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-020 U: {imm[31:12],rd,opcode}.
REQ-021 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-022 Range checks in ENC: I/S imm in [-2048,2047]; shift shamt in [0,31]; B imm in [-4096,4094] and even; U imm[11:0]=0; J imm in [-2^20,2^20-2] and even; fmt 6/7 illegal.
REQ-023 Check failure: err=1 for the ENC->IDLE cycle only, no mem_we, address/count unchanged, last ignored.
REQ-024 WR: mem_we=1, mem_addr and mem_wdata held stable until mem_ack sampled high.
REQ-025 On mem_ack in WR: mem_addr+=4, count+=1, mem_we=0 next cycle; then DONE if last, else IDLE.
REQ-026 full=1 when count==DEPTH; in_ready=0 while full; cleared only by clear/reset.
REQ-027 DONE: done=1, in_ready=0, remains until clear or reset.
REQ-028 mem_addr never wraps; count saturates at DEPTH.
REQ-029 clear has priority over all FSM activity including mid-WR (write abandoned, mem_we=0 next cycle).
REQ-030 mem_ack outside WR ignored.

Reset
REQ-031 rst_n low asynchronously: state IDLE, mem_addr=BASE_ADDR, count=0, mem_wdata=0, mem_we=0, err=0, done=0, full=0.
REQ-032 in_ready=1 on first edge after rst_n deasserts; reset during WR abandons the write.

Verification
REQ-033 I-type addi x1,x0,5 (opcode 0010011, funct3 000, rd 1, rs1 0, imm 5) -> mem_wdata=32'h00500093, mem_addr=BASE_ADDR, mem_we one cycle after accept.
REQ-034 R-type sub x3,x1,x2 (funct7 0100000, opcode 0110011) -> 32'h402081B3 at BASE_ADDR+4.
REQ-035 B-type beq x1,x2,imm=-8 (opcode 1100011) -> 32'hFE208CE3; B with imm=5 -> err pulse, no mem_we, address unchanged.
REQ-036 mem_ack held low 3 cycles in WR -> mem_we, mem_addr, mem_wdata stable, in_ready=0; ack -> addr+4 next cycle.
REQ-037 DEPTH=2: two writes -> full=1, in_ready=0; last=1 on a bundle -> done=1 after ack; clear -> addr=BASE_ADDR, in_ready=1.
REQ-038 rst_n pulsed low mid-WR -> all outputs at reset values immediately, no further mem_we.
